mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory (MEM) stage between the ALU stage and the writeback unit; it takes the place of the direct EX->WB connection.
- Loads and stores are executed against the data RAM port: byte/half/word lane steering, sign/zero extension, misalignment check and bus timeout.
- Non-memory results pass through in one cycle.
- It stalls the upstream stage through a valid/ready handshake while a RAM access is outstanding.

Parameters:
- ADDR_W, 16, width of the data RAM byte address.
- TIMEOUT, 255, maximum cycles mem_req may stay high without mem_ack before the access is aborted (1..65535).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- ex_valid  input  1  upstream holds a valid operation
- ex_ready  output  1  unit can accept an operation this cycle
- ex_op  input  2  mem_op_t: MEM_NONE, MEM_LOAD, MEM_STORE
- ex_size  input  2  mem_size_t: SZ_BYTE, SZ_HALF, SZ_WORD
- ex_unsigned  input  1  zero-extend load (LBU/LHU)
- ex_alu_result  input  32  effective address for mem ops, result for MEM_NONE
- ex_store_data  input  32  rs2 value for stores
- ex_wr_addr  input  5  destination register
- wb_valid  output  1  one-cycle pulse, result for writeback
- wb_result  output  32  value to write
- wb_wr_addr  output  5  destination register, 0 means no write
- mem_req  output  1  RAM request
- mem_we  output  1  1 = write
- mem_addr  output  ADDR_W  word-aligned byte address, bits [1:0] = 0
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-steered store data
- mem_rdata  input  32  read data, valid in the mem_ack cycle
- mem_ack  input  1  access complete
- misaligned_err  output  1  one-cycle pulse
- bus_err  output  1  one-cycle pulse on timeout

Behaviour:
- Reset: state IDLE; timeout counter 0; every output 0 except ex_ready = 1. Asserting reset mid-access drops mem_req immediately, discards the pending operation and produces no wb_valid.
- FSM states are IDLE and BUSY. ex_ready = (state == IDLE). An operation is accepted in cycle T when ex_valid && ex_ready.
- MEM_NONE accepted at T: wb_valid = 1 at T+1, with wb_result = ex_alu_result and wb_wr_addr = ex_wr_addr. Stays in IDLE, so throughput is 1 per cycle.
- Misaligned access: half with addr[0] = 1, or word with addr[1:0] != 0.
  - No RAM access is made.
  - At T+1: wb_valid = 1, wb_wr_addr = 0, wb_result = 0, misaligned_err = 1.
  - Stays in IDLE.
- Aligned load/store accepted at T: enter BUSY. From T+1, drive mem_req = 1 with mem_addr, mem_we, mem_be and mem_wdata registered and held stable until the mem_ack cycle A (A >= T+1).
  - In cycle A, capture mem_rdata.
  - At A+1: mem_req = 0, wb_valid = 1, state back to IDLE. The next op can be accepted at A+1.
  - Minimum latency is 2 cycles.
- mem_ack while mem_req = 0 is ignored.
- Store lane steering:
  - Byte: mem_wdata = {4{d[7:0]}}, mem_be = 4'b0001 << addr[1:0].
  - Half: mem_wdata = {2{d[15:0]}}, mem_be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: mem_wdata = d, mem_be = 4'b1111.
  - Store completion gives wb_wr_addr = 0.
- Load extraction: select the byte lane addr[1:0] or half lane addr[1], then sign-extend (ex_unsigned = 0) or zero-extend to 32 bits. For loads mem_we = 0, and mem_be is computed as for stores. wb_wr_addr = ex_wr_addr.
- Timeout: the counter clears on accept and increments every BUSY cycle without ack. If it reaches TIMEOUT:
  - Next cycle: mem_req = 0, bus_err = 1, wb_valid = 1, wb_wr_addr = 0, back to IDLE.
  - If mem_ack arrives in the same cycle the counter reaches TIMEOUT, the ack wins.
- Only one access is ever outstanding. Inputs are sampled only at accept.

Decomposition:
- Add mem_op_t and mem_size_t enums to the shared pipeline/ALU enums package.
- Add an EX_MEM struct (op, size, unsigned, alu_result, store_data, wr_addr) alongside the existing stage-register structs.
- One combinational sub-module, mem_lane_align, holds the store steering/byte-enable generation and the load extraction/extension.
- The FSM, counter and registers stay in mem_access_unit.

Test Plan:
- MEM_NONE stream of results 1, 2, 3 (rd = 5, 6, 7) on consecutive cycles -> wb_valid three consecutive cycles with the same values, ex_ready constantly 1.
- LB addr 0x0103 with mem_rdata 0x80FF_1234, ack on the first req cycle -> mem_addr 0x0100, mem_be 4'b1000, wb_result 0xFFFF_FF80 at T+2. Same access as LBU -> 0x0000_0080.
- SH addr 0x0042, data 0xDEAD_BEEF, ack after 3 wait cycles -> mem_wdata 0xBEEF_BEEF, mem_be 4'b1100, mem_we = 1 held stable for 4 cycles, ex_ready = 0 throughout, wb_valid with wb_wr_addr 0 the cycle after ack.
- LW addr 0x0006 -> no mem_req, misaligned_err and wb_valid at T+1, wb_wr_addr 0.
- TIMEOUT = 4, load never acked -> mem_req high for 4 cycles, then bus_err and wb_valid pulse together with mem_req low, ex_ready back to 1.
- Reset asserted in the second wait cycle of a load -> mem_req, wb_valid and ex_ready respond asynchronously (ex_ready = 1); a late mem_ack after reset release is ignored.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared pipeline enums and stage-register structs for the memory stage.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } mem_size_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mau_state_t;

    // EX -> MEM stage register contents
    typedef struct packed {
        mem_op_t     op;
        mem_size_t   size;
        logic        is_unsigned;
        logic [31:0] alu_result;
        logic [31:0] store_data;
        logic [4:0]  wr_addr;
    } ex_mem_t;

    // Timeout counter width; TIMEOUT is limited to 1..65535
    localparam int CNT_W = 16;

    // Half must be 2-byte aligned, word 4-byte aligned; bytes never fault.
    // The unused encoding 2'd3 is treated as a word.
    function automatic logic is_misaligned(input mem_size_t size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane.sv
// Combinational lane steering: store data replication / byte enables and
// load lane extraction with sign or zero extension.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic [31:0] load_data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rdata[{addr_lo, 3'b000} +: 8];
    assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Select lane pattern by access size; anything not byte/half is a word
    always_comb begin
        wdata     = store_data;
        be        = 4'b1111;
        load_data = rdata;
        case (size)
            SZ_BYTE: begin
                wdata     = {4{store_data[7:0]}};
                be        = 4'b0001 << addr_lo;
                load_data = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            end
            SZ_HALF: begin
                wdata     = {2{store_data[15:0]}};
                be        = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = {{16{~is_unsigned & half_v[15]}}, half_v};
            end
            default: begin
                wdata     = store_data;
                be        = 4'b1111;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage: passes ALU results through, runs one load/store at a time
// against the data RAM port, flags misaligned accesses and bus timeouts.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [1:0]        ex_op,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [31:0]       ex_alu_result,
    input  logic [31:0]       ex_store_data,
    input  logic [4:0]        ex_wr_addr,
    output logic              wb_valid,
    output logic [31:0]       wb_result,
    output logic [4:0]        wb_wr_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              misaligned_err,
    output logic              bus_err
);

    ex_mem_t ex_in;
    assign ex_in = '{op:          mem_op_t'(ex_op),
                     size:        mem_size_t'(ex_size),
                     is_unsigned: ex_unsigned,
                     alu_result:  ex_alu_result,
                     store_data:  ex_store_data,
                     wr_addr:     ex_wr_addr};

    mau_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W:0]    cnt_inc;

    // Fields of the outstanding access needed at completion
    mem_size_t         size_q, size_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              uns_q, uns_d;
    logic              is_load_q, is_load_d;
    logic [4:0]        rd_q, rd_d;

    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_result_q, wb_result_d;
    logic [4:0]        wb_wr_addr_q, wb_wr_addr_d;
    logic              mis_err_q, mis_err_d;
    logic              bus_err_q, bus_err_d;

    logic              busy;
    mem_size_t         al_size;
    logic [1:0]        al_addr_lo;
    logic              al_uns;
    logic [31:0]       al_wdata;
    logic [3:0]        al_be;
    logic [31:0]       al_load;

    assign busy    = (state_q == ST_BUSY);
    assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // One aligner serves both phases: incoming op when idle, held op when busy
    assign al_size    = busy ? size_q    : ex_in.size;
    assign al_addr_lo = busy ? addr_lo_q : ex_in.alu_result[1:0];
    assign al_uns     = busy ? uns_q     : ex_in.is_unsigned;

    mem_lane_align u_align (
        .size        (al_size),
        .addr_lo     (al_addr_lo),
        .is_unsigned (al_uns),
        .store_data  (ex_in.store_data),
        .rdata       (mem_rdata),
        .wdata       (al_wdata),
        .be          (al_be),
        .load_data   (al_load)
    );

    // Next-state, access capture and writeback pulse generation
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        size_d       = size_q;
        addr_lo_d    = addr_lo_q;
        uns_d        = uns_q;
        is_load_d    = is_load_q;
        rd_d         = rd_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_result_d  = 32'd0;
        wb_wr_addr_d = 5'd0;
        mis_err_d    = 1'b0;
        bus_err_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ex_valid) begin
                    if (ex_in.op == MEM_NONE) begin
                        wb_valid_d   = 1'b1;
                        wb_result_d  = ex_in.alu_result;
                        wb_wr_addr_d = ex_in.wr_addr;
                    end else if (is_misaligned(ex_in.size, ex_in.alu_result[1:0])) begin
                        wb_valid_d = 1'b1;
                        mis_err_d  = 1'b1;
                    end else begin
                        state_d     = ST_BUSY;
                        cnt_d       = '0;
                        size_d      = ex_in.size;
                        addr_lo_d   = ex_in.alu_result[1:0];
                        uns_d       = ex_in.is_unsigned;
                        is_load_d   = (ex_in.op == MEM_LOAD);
                        rd_d        = ex_in.wr_addr;
                        mem_we_d    = (ex_in.op == MEM_STORE);
                        mem_addr_d  = {ex_in.alu_result[ADDR_W-1:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                    end
                end
            end
            default: begin
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    if (is_load_q) begin
                        wb_result_d  = al_load;
                        wb_wr_addr_d = rd_q;
                    end
                end else begin
                    cnt_d = cnt_inc[CNT_W-1:0];
                    if (cnt_inc == (CNT_W+1)'(TIMEOUT)) begin
                        state_d    = ST_IDLE;
                        wb_valid_d = 1'b1;
                        bus_err_d  = 1'b1;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset aborts any outstanding access
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            size_q       <= SZ_BYTE;
            addr_lo_q    <= 2'b00;
            uns_q        <= 1'b0;
            is_load_q    <= 1'b0;
            rd_q         <= 5'd0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= 4'd0;
            mem_wdata_q  <= 32'd0;
            wb_valid_q   <= 1'b0;
            wb_result_q  <= 32'd0;
            wb_wr_addr_q <= 5'd0;
            mis_err_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            size_q       <= size_d;
            addr_lo_q    <= addr_lo_d;
            uns_q        <= uns_d;
            is_load_q    <= is_load_d;
            rd_q         <= rd_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_result_q  <= wb_result_d;
            wb_wr_addr_q <= wb_wr_addr_d;
            mis_err_q    <= mis_err_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign ex_ready       = ~busy;
    assign mem_req        = busy;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_be         = mem_be_q;
    assign mem_wdata      = mem_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_result      = wb_result_q;
    assign wb_wr_addr     = wb_wr_addr_q;
    assign misaligned_err = mis_err_q;
    assign bus_err        = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus random ops
// with random ack latency, checked against a transaction-level model.
module tb_mem_access_unit;
    localparam int ADDR_W = 16;
    localparam int TO     = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              ex_valid = 1'b0;
    logic              ex_ready;
    logic [1:0]        ex_op = 2'd0;
    logic [1:0]        ex_size = 2'd0;
    logic              ex_unsigned = 1'b0;
    logic [31:0]       ex_alu_result = 32'd0;
    logic [31:0]       ex_store_data = 32'd0;
    logic [4:0]        ex_wr_addr = 5'd0;
    logic              wb_valid;
    logic [31:0]       wb_result;
    logic [4:0]        wb_wr_addr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'd0;
    logic              mem_ack = 1'b0;
    logic              misaligned_err;
    logic              bus_err;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .ex_alu_result(ex_alu_result),
        .ex_store_data(ex_store_data), .ex_wr_addr(ex_wr_addr),
        .wb_valid(wb_valid), .wb_result(wb_result), .wb_wr_addr(wb_wr_addr),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .misaligned_err(misaligned_err), .bus_err(bus_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // ---- reference model: plain arithmetic on the access rules ----
    function automatic bit m_misaligned(input int sz, input int a);
        if (sz == 1) return (a % 2) != 0;
        if (sz == 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input int a);
        int lane;
        lane = a % 4;
        if (sz == 0) return 4'(1 << lane);
        if (sz == 1) return (lane >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
        if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input int a, input bit uns,
                                           input logic [31:0] rd);
        longint v;
        v = longint'(rd >> (8 * (a % 4)));
        if (sz == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v - 256;
        end else if (sz == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v - 65536;
        end else begin
            v = longint'(rd);
        end
        return v[31:0];
    endfunction

    function automatic logic [31:0] junk;
        return $urandom;
    endfunction

    // Issue one op; ack_dly = req cycles without ack before the ack cycle
    task automatic do_op(input int op, input int sz, input bit uns, input logic [31:0] addr,
                         input logic [31:0] sd, input logic [4:0] rd, input int ack_dly,
                         input logic [31:0] rdata, input string nm);
        int a;
        logic [ADDR_W-1:0] exp_addr;
        a = int'(addr[1:0]);
        exp_addr = {addr[ADDR_W-1:2], 2'b00};
        ex_valid = 1'b1; ex_op = 2'(op); ex_size = 2'(sz); ex_unsigned = uns;
        ex_alu_result = addr; ex_store_data = sd; ex_wr_addr = rd;
        chk({nm, ".ready_acc"}, 32'(ex_ready), 32'd1);
        step;
        ex_valid = $urandom_range(0, 1); ex_op = 2'($urandom_range(0, 2));
        ex_size = 2'($urandom_range(0, 2)); ex_alu_result = junk(); ex_store_data = junk();
        ex_wr_addr = 5'($urandom); ex_unsigned = 1'($urandom);
        if (op == 0) begin
            ex_valid = 1'b0;
            chk({nm, ".wbv"}, 32'(wb_valid), 32'd1);
            chk({nm, ".res"}, wb_result, addr);
            chk({nm, ".rd"}, 32'(wb_wr_addr), 32'(rd));
            chk({nm, ".req"}, 32'(mem_req), 32'd0);
            return;
        end
        if (m_misaligned(sz, a)) begin
            ex_valid = 1'b0;
            chk({nm, ".wbv"}, 32'(wb_valid), 32'd1);
            chk({nm, ".mis"}, 32'(misaligned_err), 32'd1);
            chk({nm, ".rd"}, 32'(wb_wr_addr), 32'd0);
            chk({nm, ".res"}, wb_result, 32'd0);
            chk({nm, ".req"}, 32'(mem_req), 32'd0);
            return;
        end
        for (int k = 0; k < TO; k++) begin
            chk({nm, ".req"}, 32'(mem_req), 32'd1);
            chk({nm, ".rdy"}, 32'(ex_ready), 32'd0);
            chk({nm, ".addr"}, 32'(mem_addr), 32'(exp_addr));
            chk({nm, ".we"}, 32'(mem_we), 32'(op == 2));
            chk({nm, ".be"}, 32'(mem_be), 32'(m_be(sz, a)));
            if (op == 2) chk({nm, ".wd"}, mem_wdata, m_wdata(sz, sd));
            chk({nm, ".wbv_w"}, 32'(wb_valid), 32'd0);
            if (k == ack_dly || k == TO - 1) ex_valid = 1'b0;
            if (k == ack_dly) begin
                mem_ack = 1'b1; mem_rdata = rdata;
                step;
                mem_ack = 1'b0; mem_rdata = junk();
                chk({nm, ".wbv"}, 32'(wb_valid), 32'd1);
                chk({nm, ".req_end"}, 32'(mem_req), 32'd0);
                chk({nm, ".bus"}, 32'(bus_err), 32'd0);
                chk({nm, ".rd"}, 32'(wb_wr_addr), (op == 1) ? 32'(rd) : 32'd0);
                if (op == 1) chk({nm, ".ld"}, wb_result, m_load(sz, a, uns, rdata));
                return;
            end
            mem_rdata = junk();
            step;
        end
        chk({nm, ".bus"}, 32'(bus_err), 32'd1);
        chk({nm, ".wbv"}, 32'(wb_valid), 32'd1);
        chk({nm, ".req_end"}, 32'(mem_req), 32'd0);
        chk({nm, ".rd"}, 32'(wb_wr_addr), 32'd0);
        chk({nm, ".rdy_end"}, 32'(ex_ready), 32'd1);
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.ready", 32'(ex_ready), 32'd1);
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.wbv", 32'(wb_valid), 32'd0);
        chk("rst.errs", {30'd0, misaligned_err, bus_err}, 32'd0);
        chk("rst.be", 32'(mem_be), 32'd0);
        step;
        reset = 1'b0;
        step;

        // back-to-back pass-through
        do_op(0, 0, 0, 32'd1, 0, 5'd5, 0, 0, "none1");
        do_op(0, 0, 0, 32'd2, 0, 5'd6, 0, 0, "none2");
        do_op(0, 0, 0, 32'd3, 0, 5'd7, 0, 0, "none3");
        step;
        chk("none.pulse_end", 32'(wb_valid), 32'd0);

        do_op(1, 0, 0, 32'h0103, 0, 5'd3, 0, 32'h80FF_1234, "lb");
        do_op(1, 0, 1, 32'h0103, 0, 5'd3, 0, 32'h80FF_1234, "lbu");
        do_op(2, 1, 0, 32'h0042, 32'hDEAD_BEEF, 5'd9, 3, 0, "sh");
        do_op(1, 2, 0, 32'h0006, 0, 5'd4, 0, 0, "lw_mis");
        do_op(1, 2, 0, 32'h0010, 0, 5'd4, 99, 0, "lw_to");

        // ack with no request outstanding
        mem_ack = 1'b1;
        step;
        mem_ack = 1'b0;
        chk("stray_ack.wbv", 32'(wb_valid), 32'd0);
        chk("stray_ack.req", 32'(mem_req), 32'd0);

        // reset in the second wait cycle of a load
        ex_valid = 1'b1; ex_op = 2'd1; ex_size = 2'd2; ex_alu_result = 32'h0020; ex_wr_addr = 5'd8;
        step;
        ex_valid = 1'b0;
        chk("rstmid.req1", 32'(mem_req), 32'd1);
        step;
        chk("rstmid.req2", 32'(mem_req), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rstmid.req", 32'(mem_req), 32'd0);
        chk("rstmid.ready", 32'(ex_ready), 32'd1);
        chk("rstmid.wbv", 32'(wb_valid), 32'd0);
        step;
        reset = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        step;
        mem_ack = 1'b0;
        chk("rstmid.late_ack", 32'(wb_valid), 32'd0);
        chk("rstmid.late_req", 32'(mem_req), 32'd0);

        // random ops with random ack latency (some beyond the timeout)
        for (int i = 0; i < 120; i++) begin
            int op, sz, dly;
            logic [31:0] ad;
            op  = $urandom_range(0, 2);
            sz  = $urandom_range(0, 2);
            dly = $urandom_range(0, TO + 1);
            ad  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 1) ad[0] = 1'b0;
                if (sz == 2) ad[1:0] = 2'b00;
            end
            do_op(op, sz, 1'($urandom), ad, $urandom, 5'($urandom), dly, $urandom,
                  $sformatf("rnd%0d", i));
            if ($urandom_range(0, 2) == 0) step;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
